// File: rtl/pipe_stage_chain_pkg.sv
// pipe_pkg: shared constants for elastic inter-stage registers.
// Control-bit indices are common to every core stage.
package pipe_pkg;

  localparam int MAX_DEPTH = 4;

  localparam int CTRL_MEMTOREG = 0;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_BRANCH   = 4;

  function automatic int occ_w(input int entries);
    return $clog2(entries + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_chain_slice.sv
// pipe_slice: one elastic register slice, optional skid entry.
// Control is zeroed whenever the slot is empty.
module pipe_slice
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int SKID   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              i_valid,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_dn_ready,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy,
  output logic [1:0]        o_cnt
);

  logic              r_mv;
  logic [CTRL_W-1:0] r_mc;
  logic [DATA_W-1:0] r_md;
  logic              w_sv;
  logic              w_free;

  assign w_free = ~r_mv | i_dn_ready;

  if (SKID == 0) begin : g_plain
    assign w_sv = 1'b0;

    // Main slot loads whenever it is empty or draining.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_mv <= 1'b0;
        r_mc <= '0;
        r_md <= '0;
      end else if (flush) begin
        r_mv <= 1'b0;
      end else if (w_free) begin
        r_mv <= i_valid;
        if (i_valid) begin
          r_mc <= i_ctrl;
          r_md <= i_data;
        end
      end
    end
  end else begin : g_skid
    logic              r_sv;
    logic [CTRL_W-1:0] r_sc;
    logic [DATA_W-1:0] r_sd;

    assign w_sv = r_sv;

    // Main refills from skid first; skid parks a beat on stall.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_mv <= 1'b0;
        r_mc <= '0;
        r_md <= '0;
        r_sv <= 1'b0;
        r_sc <= '0;
        r_sd <= '0;
      end else if (flush) begin
        r_mv <= 1'b0;
        r_sv <= 1'b0;
      end else if (w_free) begin
        if (r_sv) begin
          r_mv <= 1'b1;
          r_mc <= r_sc;
          r_md <= r_sd;
          r_sv <= 1'b0;
        end else begin
          r_mv <= i_valid;
          if (i_valid) begin
            r_mc <= i_ctrl;
            r_md <= i_data;
          end
        end
      end else if (i_valid && !r_sv) begin
        r_sv <= 1'b1;
        r_sc <= i_ctrl;
        r_sd <= i_data;
      end
    end
  end

  assign o_valid = r_mv;
  assign o_ctrl  = r_mv ? r_mc : '0;
  assign o_data  = r_md;
  assign o_busy  = (SKID != 0) ? w_sv : r_mv;
  assign o_cnt   = {1'b0, r_mv} + {1'b0, w_sv};

endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH elastic slices between two core stages.
// Bubbles carry zero control; flush empties every slot.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int DEPTH  = 1,
  parameter int SKID   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [occ_w(DEPTH*(1+SKID))-1:0] occupancy
);

  localparam int OCC_W = occ_w(DEPTH * (1 + SKID));

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("pipe_stage_chain: DEPTH must be 1..%0d", MAX_DEPTH);
  end

  logic              r_en;
  logic [DEPTH:0]    w_v;
  logic [CTRL_W-1:0] w_c [DEPTH+1];
  logic [DATA_W-1:0] w_d [DEPTH+1];
  logic [DEPTH-1:0]  w_busy;
  logic [DEPTH:0]    w_rdy;
  logic [1:0]        w_cnt [DEPTH];

  // Input side stays closed until the first edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_en <= 1'b0;
    else     r_en <= 1'b1;
  end

  // Ready ripples tail-ward; a skid slice cuts the ripple.
  always_comb begin : p_rdy
    logic w_carry;
    w_carry      = out_ready;
    w_rdy        = '0;
    w_rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (SKID != 0) w_carry = ~w_busy[i];
      else           w_carry = ~w_busy[i] | w_carry;
      w_rdy[i] = w_carry;
    end
  end

  assign in_ready = r_en & ~flush & w_rdy[0];
  assign w_v[0]   = in_valid & in_ready;
  assign w_c[0]   = in_ctrl;
  assign w_d[0]   = in_data;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slice
    pipe_slice #(
      .DATA_W(DATA_W),
      .CTRL_W(CTRL_W),
      .SKID  (SKID)
    ) u_slice (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .i_valid   (w_v[g]),
      .i_ctrl    (w_c[g]),
      .i_data    (w_d[g]),
      .i_dn_ready(w_rdy[g+1]),
      .o_valid   (w_v[g+1]),
      .o_ctrl    (w_c[g+1]),
      .o_data    (w_d[g+1]),
      .o_busy    (w_busy[g]),
      .o_cnt     (w_cnt[g])
    );
  end

  // Occupancy is the sum of per-slice live entries.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++)
      occupancy = occupancy + OCC_W'(w_cnt[i]);
  end

  assign out_valid = w_v[DEPTH];
  assign out_ctrl  = w_c[DEPTH];
  assign out_data  = w_d[DEPTH];

endmodule
